// File: rtl/cam_tlb_rr.sv
// cam_tlb_rr: sliced-RAM CAM TLB with pipelined lookup, command handshake and round-robin allocation.
// Optional hit/miss counters enabled by defining CAM_TLB_HIT_CNT_EN.
module cam_tlb_rr #(
  parameter int KEY_WIDTH     = 16,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int ADDR_WIDTH    = 3,
  parameter int SLICE_WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [KEY_WIDTH-1:0]       cmd_key,
  input  logic [PAYLOAD_WIDTH-1:0]   cmd_payload,
  output logic                       cmd_done,
  output logic [ADDR_WIDTH-1:0]      cmd_done_addr,
  input  logic                       lk_valid,
  output logic                       lk_ready,
  input  logic [KEY_WIDTH-1:0]       lk_key,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic [ADDR_WIDTH-1:0]      rsp_addr,
  output logic [PAYLOAD_WIDTH-1:0]   rsp_payload,
  output logic [(1<<ADDR_WIDTH)-1:0] valid_mask,
  output logic                       busy,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int SLICES = (KEY_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int ROWS   = 1 << SLICE_WIDTH;
  localparam int PKW    = SLICES * SLICE_WIDTH;
  localparam logic [1:0] OP_ALLOC  = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;
  typedef enum logic [2:0] {INIT, IDLE, OLD_RD, CLR_RD, CLR_WR, SET_RD, SET_WR, DONE} state_t;
  state_t state, state_nx;
  logic [DEPTH-1:0]         sram [SLICES][ROWS];
  logic [KEY_WIDTH-1:0]     kram [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] pram [DEPTH];
  logic [DEPTH-1:0]         rows [SLICES];
  logic [DEPTH-1:0]         lk_rows [SLICES];
  logic [SLICE_WIDTH-1:0]   sweep;
  logic [ADDR_WIDTH-1:0]    rr_ptr, tgt, acc_tgt, free_idx, hit_idx;
  logic [1:0]               op;
  logic                     flushing, free_found, hit_any, cmd_fire, lk_fire, v0, v1;
  logic [KEY_WIDTH-1:0]     new_key, old_key, rmw_key, key0;
  logic [PAYLOAD_WIDTH-1:0] new_pl;
  logic [DEPTH-1:0]         onehot, vm1, match;
  function automatic logic [SLICE_WIDTH-1:0] sl(input logic [KEY_WIDTH-1:0] k, input int s);
    logic [PKW-1:0] p;
    p = PKW'(k);
    return p[s*SLICE_WIDTH +: SLICE_WIDTH];
  endfunction
  assign busy      = state != IDLE;
  assign cmd_ready = state == IDLE;
  assign lk_ready  = state == IDLE && !cmd_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign lk_fire   = lk_valid && lk_ready;
  assign onehot    = DEPTH'(1) << tgt;
  assign rmw_key   = (state == CLR_RD || state == CLR_WR) ? old_key : new_key;
  assign acc_tgt   = cmd_op == OP_ALLOC ? (free_found ? free_idx : rr_ptr) : cmd_addr;
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit_any    = 1'b0;
    hit_idx    = '0;
    match      = vm1;
    for (int s = 0; s < SLICES; s++) match = match & lk_rows[s];
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_mask[i]) begin free_found = 1'b1; free_idx = ADDR_WIDTH'(i); end
      if (match[i]) begin hit_any = 1'b1; hit_idx = ADDR_WIDTH'(i); end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (sweep == '0) state_nx = flushing ? DONE : IDLE;
      IDLE:    if (cmd_fire) state_nx = cmd_op == OP_FLUSH ? INIT : valid_mask[acc_tgt] ? OLD_RD :
                                        cmd_op == OP_DELETE ? DONE : SET_RD;
      OLD_RD:  state_nx = CLR_RD;
      CLR_RD:  state_nx = CLR_WR;
      CLR_WR:  state_nx = op == OP_DELETE ? DONE : SET_RD;
      SET_RD:  state_nx = SET_WR;
      SET_WR:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      sweep         <= '1;
      valid_mask    <= '0;
      rr_ptr        <= '0;
      flushing      <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_done_addr <= '0;
      op            <= '0;
      tgt           <= '0;
      new_key       <= '0;
      new_pl        <= '0;
      old_key       <= '0;
    end else begin
      state    <= state_nx;
      cmd_done <= state == DONE;
      if (state == DONE) cmd_done_addr <= op == OP_FLUSH ? '0 : tgt;
      if (state == INIT) sweep <= sweep - 1'b1;
      if (state == INIT && sweep == '0) flushing <= 1'b0;
      if (cmd_fire) begin
        op      <= cmd_op;
        tgt     <= acc_tgt;
        new_key <= cmd_key;
        new_pl  <= cmd_payload;
        if (cmd_op == OP_FLUSH) begin
          valid_mask <= '0;
          rr_ptr     <= '0;
          sweep      <= '1;
          flushing   <= 1'b1;
        end
        if (cmd_op == OP_ALLOC && !free_found) rr_ptr <= rr_ptr + 1'b1;
      end
      if (state == OLD_RD) old_key <= kram[tgt];
      if (state == CLR_WR) valid_mask[tgt] <= 1'b0;
      if (state == SET_WR) valid_mask[tgt] <= 1'b1;
    end
  end
  // Storage arrays carry no reset; INIT sweeps the slice RAMs and valid bits gate everything else.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SLICES; s++) begin
      if (state == INIT) sram[s][sweep] <= '0;
      if (state == CLR_RD || state == SET_RD) rows[s] <= sram[s][sl(rmw_key, s)];
      if (state == CLR_WR) sram[s][sl(rmw_key, s)] <= rows[s] & ~onehot;
      if (state == SET_WR) sram[s][sl(rmw_key, s)] <= rows[s] | onehot;
      lk_rows[s] <= sram[s][sl(key0, s)];
    end
    if (state == SET_WR) begin
      kram[tgt] <= new_key;
      pram[tgt] <= new_pl;
    end
  end
  // valid_mask is captured alongside the slice reads so in-flight lookups see pre-command contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0          <= 1'b0;
      key0        <= '0;
      v1          <= 1'b0;
      vm1         <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_addr    <= '0;
      rsp_payload <= '0;
    end else begin
      v0        <= lk_fire;
      v1        <= v0;
      vm1       <= valid_mask;
      rsp_valid <= v1;
      if (lk_fire) key0 <= lk_key;
      if (v1) begin
        rsp_hit     <= hit_any;
        rsp_addr    <= hit_idx;
        rsp_payload <= hit_any ? pram[hit_idx] : '0;
      end
    end
  end
`ifdef CAM_TLB_HIT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cmd_fire && cmd_op == OP_FLUSH) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rsp_valid && rsp_hit) begin
      hit_count  <= hit_count == '1 ? hit_count : hit_count + 32'd1;
    end else if (rsp_valid) begin
      miss_count <= miss_count == '1 ? miss_count : miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cam_tlb_rr.sv
// tb_cam_tlb_rr: randomized self-checking bench for cam_tlb_rr against an entry-table reference model.
module tb_cam_tlb_rr;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_done, lk_valid, lk_ready, rsp_valid, rsp_hit, busy;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_addr, cmd_done_addr, rsp_addr;
  logic [15:0] cmd_key, cmd_payload, lk_key, rsp_payload;
  logic [7:0]  valid_mask;
  logic [31:0] hit_count, miss_count;
  int checks = 0, failures = 0;
  logic [7:0]  mv;
  logic [15:0] mk [8];
  logic [15:0] mp [8];
  int rr, mhit, mmiss;
  cam_tlb_rr dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_key(cmd_key), .cmd_payload(cmd_payload), .cmd_done(cmd_done),
    .cmd_done_addr(cmd_done_addr), .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_payload(rsp_payload),
    .valid_mask(valid_mask), .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] mlook(input logic [15:0] k);
    for (int i = 0; i < 8; i++) if (mv[i] && mk[i] == k) return {1'b1, 3'(i), mp[i]};
    return 20'h0;
  endfunction
  task automatic mreset();
    mv = '0; rr = 0; mhit = 0; mmiss = 0;
  endtask
  task automatic mcmd(input logic [1:0] op, input logic [2:0] a, input logic [15:0] k,
                      input logic [15:0] p, output int tgt, output int lat);
    tgt = int'(a);
    lat = 0;
    if (op == 2'd1) begin
      tgt = -1;
      for (int i = 7; i >= 0; i--) if (!mv[i]) tgt = i;
      if (tgt < 0) begin tgt = rr; rr = (rr + 1) % 8; end
    end
    if (op == 2'd3) begin
      tgt = 0; lat = 17; mv = '0; rr = 0; mhit = 0; mmiss = 0;
    end else if (op == 2'd2) begin
      lat = mv[tgt] ? 4 : 1; mv[tgt] = 1'b0;
    end else begin
      lat = mv[tgt] ? 6 : 3; mv[tgt] = 1'b1; mk[tgt] = k; mp[tgt] = p;
    end
  endtask
  task automatic check_rsp(input logic [19:0] e);
    check("rsp_hit", rsp_hit, e[19]);
    check("rsp_payload", rsp_payload, e[15:0]);
    if (e[19]) check("rsp_addr", rsp_addr, e[18:16]);
    if (e[19]) mhit++; else mmiss++;
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [15:0] k, input logic [15:0] p);
    int tgt, lat, n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_key = k; cmd_payload = p;
    #1 check("cmd_ready", cmd_ready, 1);
    mcmd(op, a, k, p, tgt, lat);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_done && n < 40) begin @(negedge clk); n++; end
    check("cmd_latency", n, lat);
    check("cmd_done_addr", cmd_done_addr, tgt);
    check("valid_mask", valid_mask, mv);
  endtask
  task automatic do_lookup(input logic [15:0] k);
    logic [19:0] e;
    int n;
    @(negedge clk);
    lk_valid = 1'b1; lk_key = k;
    #1 check("lk_ready", lk_ready, 1);
    e = mlook(k);
    @(posedge clk);
    @(negedge clk);
    lk_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 6) begin @(negedge clk); n++; end
    check("lk_latency", n, 2);
    check_rsp(e);
  endtask
  task automatic wait_init();
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    check("init_cycles", n, 16);
    check("ready_after_init", cmd_ready, 1);
    check("vm_after_init", valid_mask, 0);
  endtask
  task automatic reset_checks();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_lk_ready", lk_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_rsp", {rsp_valid, rsp_hit, rsp_addr, rsp_payload}, 0);
    check("rst_vm", valid_mask, 0);
    check("rst_counts", {hit_count, miss_count}, 0);
  endtask
  task automatic stream();
    logic [19:0] q [$];
    logic [19:0] e;
    logic [15:0] k;
    int acc = 0, got = 0, tgt, lat;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got++;
        if (q.size() > 0) begin e = q.pop_front(); check_rsp(e); end
      end
      if (c < 40) begin
        k = ($urandom_range(0, 9) == 9) ? 16'h7777 : 16'h0100 + 16'($urandom_range(0, 8));
        lk_valid = 1'b1; lk_key = k;
        cmd_valid = (c == 8); cmd_op = 2'd0; cmd_addr = 3'd3; cmd_key = 16'h7777; cmd_payload = 16'h3333;
      end else begin
        lk_valid = 1'b0; cmd_valid = 1'b0;
      end
      #1;
      if (cmd_valid) check("lk_ready_cmd", lk_ready, 0);
      if (cmd_valid && cmd_ready) mcmd(cmd_op, cmd_addr, cmd_key, cmd_payload, tgt, lat);
      if (lk_valid && lk_ready) begin acc++; q.push_back(mlook(k)); end
    end
    check("stream_count", got, acc);
    check("stream_pending", q.size(), 0);
  endtask
  initial begin
    logic [15:0] k, p;
    logic [2:0] a;
    int r;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_key = '0; cmd_payload = '0;
    lk_valid = 1'b0; lk_key = '0;
    mreset();
    #3 rst_n = 1'b0;
    #1 reset_checks();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    do_lookup(16'h1234);
    do_cmd(2'd0, 3'd2, 16'hA5C3, 16'h0F0F);
    check("vm_write2", valid_mask, 8'h04);
    do_lookup(16'hA5C3);
    do_cmd(2'd0, 3'd2, 16'h1111, 16'h2222);
    do_lookup(16'hA5C3);
    do_lookup(16'h1111);
    do_cmd(2'd3, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 9; i++) do_cmd(2'd1, 3'd7, 16'h0100 + 16'(i), 16'hD000 + 16'(i));
    do_lookup(16'h0100);
    do_lookup(16'h0108);
    do_cmd(2'd2, 3'd5, 16'h0, 16'h0);
    do_lookup(16'h0105);
    do_cmd(2'd2, 3'd5, 16'h0, 16'h0);
    stream();
    do_cmd(2'd3, 3'd0, 16'h0, 16'h0);
    do_lookup(16'h0101);
    do_lookup(16'h7777);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      k = 16'hB000 | 16'($urandom_range(0, 5));
      a = 3'($urandom_range(0, 7));
      p = 16'($urandom);
      if (r < 3) do_cmd(2'd0, a, k, p);
      else if (r < 5) do_cmd(2'd1, a, k, p);
      else if (r == 5) do_cmd(2'd2, a, k, p);
      else if (r == 6 && $urandom_range(0, 3) == 0) do_cmd(2'd3, a, k, p);
      else do_lookup(k);
    end
    repeat (2) @(negedge clk);
`ifdef CAM_TLB_HIT_CNT_EN
    check("hit_count", hit_count, mhit);
    check("miss_count", miss_count, mmiss);
`else
    check("hit_count", hit_count, 0);
    check("miss_count", miss_count, 0);
`endif
    do_cmd(2'd3, 3'd0, 16'h0, 16'h0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 3'd6; cmd_key = 16'hCAFE; cmd_payload = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    mreset();
    #1 reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    do_lookup(16'hCAFE);
    do_cmd(2'd1, 3'd5, 16'h4242, 16'h0042);
    do_lookup(16'h4242);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
